can_frame_tx: RTL and testbench
===============================

Name: can_frame_tx

Overview:
Transmit-side counterpart of the receive frame storage. Accepts a fully assembled CAN frame as a parallel bit vector and serializes it MSB-first onto CAN_TX, one bit per transmit point. It inserts stuff bits over the stuffed region and flags each one on isStuff. It compares CAN_RX at every sample point to detect arbitration loss and bit errors. It sits between the frame builder and the bus line driver, alongside the bit-timing unit that supplies the tx_pt and sp strobes.

Parameters:
FRAME_W, 128, maximum frame length in bits; must be ≤ 255.
STUFF_RUN, 5, run length of identical bits that forces a stuff bit.

Ports:
clk  input  1  single system clock
reset  input  1  synchronous, active-high reset
tx_pt  input  1  one-cycle strobe at the start of each bit time; drive the next bit
sp  input  1  one-cycle strobe at the sample point; compare CAN_RX
CAN_RX  input  1  bus level read back (0 = dominant)
start  input  1  request transmission; sampled only in IDLE
frame  input  FRAME_W  frame bits; bit FRAME_W-1 is the first bit sent (SOF)
frame_len  input  8  number of frame bits to send (1..FRAME_W)
stuff_len  input  8  number of leading bits subject to stuffing (SOF..CRC)
arb_len  input  8  number of leading bits forming the arbitration field (incl. SOF)
CAN_TX  output  1  bus drive; 1 = recessive
busy  output  1  high from accepted start until done or abort
isStuff  output  1  high while the bit currently on CAN_TX is a stuff bit
done  output  1  one-cycle pulse after the sp of the last bit
arb_lost  output  1  one-cycle pulse on arbitration loss
bit_error  output  1  one-cycle pulse on bit error

Behaviour:
- Reset, checked first in every cycle: state IDLE; CAN_TX=1; busy, isStuff, done, arb_lost, bit_error all 0; counters cleared.
- States:
  - IDLE: on start with frame_len≠0, latch frame, frame_len, stuff_len and arb_len into a shift register and length registers; busy=1; go to ARMED. start with frame_len=0 is ignored.
  - ARMED: wait for tx_pt. No bit is on the bus yet, so sp is ignored. On tx_pt, drive bit 0 and go to ACTIVE.
  - ACTIVE:
    - On sp: compare, then on the final sample finish (rules below).
    - On tx_pt: drive the next bit.
- Counters: idx counts data bits already driven; run (1..5) counts consecutive identical driven bits, stuff bits included; last = the last driven bit.
- Next-bit decision at tx_pt: if run==STUFF_RUN and idx≤stuff_len and idx>0, drive ~last as a stuff bit with isStuff=1, and set run=1. Otherwise drive frame bit idx with isStuff=0; increment idx; run = (bit==last) ? run+1 : 1.
- A stuff bit is therefore still inserted after the final stuffed-region bit when the run reaches 5.
- Beyond stuff_len, run still updates, but no stuff bit is ever inserted.
- Compare at sp, on the bit currently driven:
  - Data bit with index < arb_len: CAN_TX=1 and CAN_RX=0 → arb_lost. CAN_TX=0 and CAN_RX=1 → bit_error.
  - Data bit with index in [arb_len, stuff_len), or any stuff bit: mismatch → bit_error.
  - Bits at index ≥ stuff_len (delimiters, ACK slot, EOF): not checked.
- Abort on arb_lost or bit_error: pulse the flag for one cycle; in the same edge set CAN_TX=1, busy=0, isStuff=0, state IDLE.
- Completion: at the sp where idx==frame_len, the bit is not a stuff bit, and no error is detected, pulse done; CAN_TX=1; busy=0; go to IDLE.
- tx_pt and sp in the same cycle: sp compare uses the pre-update CAN_TX; the tx_pt update applies only if no abort or completion occurred.
- start while busy is ignored. Latched inputs do not change mid-frame.
- All outputs are registered; CAN_TX changes exactly one cycle after the tx_pt cycle.

Decomposition:
- Package can_pkg: state enum {IDLE, ARMED, ACTIVE}; constants RECESSIVE=1'b1, DOMINANT=1'b0, STUFF_RUN=5. Shared with the receive path for destuffing.
- Sub-module can_stuff_gen: holds the run counter and last bit. Inputs: advance, bit, stuff_en. Outputs: stuff_now, stuff_bit. The receive side can reuse it for stuff detection.

Test Plan:
1. frame_len=4, stuff_len=4, arb_len=0, bits 1010, CAN_RX looped to CAN_TX → CAN_TX sequence 1,0,1,0; isStuff never set; done pulses at the 4th sp; busy then 0.
2. frame_len=7, stuff_len=7, bits 0000011 → CAN_TX 0,0,0,0,0,1,1,1 (6th bit is a stuff bit, isStuff=1 for that bit only); done after the 8th sp.
3. frame_len=6, stuff_len=5, bits 111110 → CAN_TX 1,1,1,1,1,0(stuff),0; no stuff bit after the unstuffed region.
4. arb_len=11, looped bus, CAN_RX forced 0 at the sp of data bit 3 (driven 1) → arb_lost pulses once; next cycle CAN_TX=1, busy=0; no done.
5. Looped bus, CAN_RX forced 1 at the sp of a driven-0 stuff bit → bit_error pulse and abort; a mismatch forced at index ≥ stuff_len → no error, done pulses normally.
6. reset asserted mid-frame → next cycle CAN_TX=1, busy=0, all pulses 0. start asserted while busy → ignored. start with frame_len=0 → ignored; stays IDLE.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions for the transmit and receive bit paths.
package can_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;
  localparam int   STUFF_RUN = 5;
endpackage

// File: rtl/can_frame_tx_if.sv
// Frame request bundle between the frame builder (master) and can_frame_tx (slave).
// Handshake: start is a request sampled only while busy=0; busy rises on the next
// edge and falls together with the single-cycle done/arb_lost/bit_error pulse.
interface can_frame_tx_if #(parameter int FRAME_W = 128);
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic [7:0]         frame_len;
  logic [7:0]         stuff_len;
  logic [7:0]         arb_len;
  logic               busy;
  logic               done;
  logic               arb_lost;
  logic               bit_error;

  modport master (output start, frame, frame_len, stuff_len, arb_len,
                  input  busy, done, arb_lost, bit_error);
  modport slave  (input  start, frame, frame_len, stuff_len, arb_len,
                  output busy, done, arb_lost, bit_error);
endinterface

// File: rtl/can_stuff_gen.sv
// Tracks the run of identical driven bits and requests a stuff bit when it saturates.
module can_stuff_gen import can_pkg::*; #(
  parameter int RUN_LEN = STUFF_RUN
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic advance_i,
  input  logic bit_i,
  input  logic stuff_en_i,
  output logic stuff_now_o,
  output logic stuff_bit_o
);
  logic [2:0] run_q, run_d;
  logic       last_q, last_d;

  // run_q==0 marks "no bit driven yet", so the first bit always starts a run of 1
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clear_i) begin
      run_d  = 3'd0;
      last_d = RECESSIVE;
    end else if (advance_i) begin
      last_d = bit_i;
      if (bit_i == last_q && run_q != 3'd0)
        run_d = (run_q == 3'(RUN_LEN)) ? run_q : run_q + 3'd1;
      else
        run_d = 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 3'd0;
      last_q <= RECESSIVE;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign stuff_now_o = stuff_en_i && (run_q == 3'(RUN_LEN));
  assign stuff_bit_o = ~last_q;
endmodule

// File: rtl/can_frame_tx.sv
// Serializes an assembled CAN frame MSB-first with bit stuffing, arbitration
// and bit-error monitoring against the read-back bus level.
module can_frame_tx import can_pkg::*; #(
  parameter int FRAME_W   = 128,
  parameter int STUFF_RUN = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_pt,
  input  logic                 sp,
  input  logic                 CAN_RX,
  output logic                 CAN_TX,
  output logic                 isStuff,
  output state_t               state_o,
  can_frame_tx_if.slave        req
);
  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [7:0]         idx_q, idx_d, flen_q, flen_d, slen_q, slen_d, alen_q, alen_d;
  logic               can_tx_q, can_tx_d, is_stuff_q, is_stuff_d, busy_q, busy_d;
  logic               done_q, done_d, arb_lost_q, arb_lost_d, bit_error_q, bit_error_d;
  logic               clear, advance, adv_bit, drive, finish, stuff_now, stuff_bit;
  logic [7:0]         cur_idx;

  can_stuff_gen #(.RUN_LEN(STUFF_RUN)) u_stuff (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .advance_i   (advance),
    .bit_i       (adv_bit),
    .stuff_en_i  ((idx_q <= slen_q) && (idx_q != 8'd0)),
    .stuff_now_o (stuff_now),
    .stuff_bit_o (stuff_bit)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    flen_d      = flen_q;
    slen_d      = slen_q;
    alen_d      = alen_q;
    can_tx_d    = can_tx_q;
    is_stuff_d  = is_stuff_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    arb_lost_d  = 1'b0;
    bit_error_d = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    adv_bit     = can_tx_q;
    drive       = 1'b0;
    finish      = 1'b0;
    cur_idx     = idx_q - 8'd1;

    case (state_q)
      IDLE: begin
        if (req.start && req.frame_len != 8'd0) begin
          shreg_d = req.frame;
          flen_d  = req.frame_len;
          slen_d  = req.stuff_len;
          alen_d  = req.arb_len;
          idx_d   = 8'd0;
          busy_d  = 1'b1;
          clear   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (tx_pt) begin
          drive   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sp) begin
          // cur_idx is the index of the data bit on the bus (idx already advanced)
          if (is_stuff_q) begin
            bit_error_d = (CAN_RX != can_tx_q);
          end else if (cur_idx < alen_q) begin
            arb_lost_d  = (can_tx_q == RECESSIVE) && (CAN_RX == DOMINANT);
            bit_error_d = (can_tx_q == DOMINANT) && (CAN_RX == RECESSIVE);
          end else if (cur_idx < slen_q) begin
            bit_error_d = (CAN_RX != can_tx_q);
          end
          if (arb_lost_d || bit_error_d) begin
            finish = 1'b1;
          end else if (idx_q == flen_q && !is_stuff_q) begin
            finish = 1'b1;
            done_d = 1'b1;
          end
        end
        if (finish) begin
          can_tx_d   = RECESSIVE;
          is_stuff_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (tx_pt) begin
          drive = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drive) begin
      advance = 1'b1;
      if (stuff_now) begin
        can_tx_d   = stuff_bit;
        is_stuff_d = 1'b1;
        adv_bit    = stuff_bit;
      end else begin
        can_tx_d   = shreg_q[FRAME_W-1];
        is_stuff_d = 1'b0;
        adv_bit    = shreg_q[FRAME_W-1];
        shreg_d    = shreg_q << 1;
        idx_d      = idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= 8'd0;
      flen_q      <= 8'd0;
      slen_q      <= 8'd0;
      alen_q      <= 8'd0;
      can_tx_q    <= RECESSIVE;
      is_stuff_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arb_lost_q  <= 1'b0;
      bit_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      flen_q      <= flen_d;
      slen_q      <= slen_d;
      alen_q      <= alen_d;
      can_tx_q    <= can_tx_d;
      is_stuff_q  <= is_stuff_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      arb_lost_q  <= arb_lost_d;
      bit_error_q <= bit_error_d;
    end
  end

  assign CAN_TX        = can_tx_q;
  assign isStuff       = is_stuff_q;
  assign state_o       = state_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.arb_lost  = arb_lost_q;
  assign req.bit_error = bit_error_q;
endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: stuffing, arbitration loss, bit errors, reset and start filtering.
module tb_can_frame_tx;
  import can_pkg::*;

  logic   clk = 1'b0;
  logic   reset, tx_pt, sp, force_en, force_val;
  logic   can_tx, can_rx, is_stuff;
  state_t state;
  int     checks = 0;
  int     errors = 0;

  can_frame_tx_if #(.FRAME_W(16)) req();

  assign can_rx = force_en ? force_val : can_tx;

  can_frame_tx #(.FRAME_W(16), .STUFF_RUN(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_pt   (tx_pt),
    .sp      (sp),
    .CAN_RX  (can_rx),
    .CAN_TX  (can_tx),
    .isStuff (is_stuff),
    .state_o (state),
    .req     (req)
  );

  always #5 clk = ~clk;

  task automatic start_frame(input logic [15:0] f, input logic [7:0] fl, input logic [7:0] sl,
                             input logic [7:0] al);
    @(negedge clk);
    req.frame = f; req.frame_len = fl; req.stuff_len = sl; req.arb_len = al; req.start = 1'b1;
    @(negedge clk);
    req.start = 1'b0;
  endtask

  // One bit time: tx_pt, then sp (optionally with a forced bus level); returns observed outputs.
  task automatic send_bit(input logic fe, input logic fv, output logic tx, output logic st,
                          output logic dn, output logic al, output logic be);
    @(negedge clk) tx_pt = 1'b1;
    @(negedge clk) tx_pt = 1'b0;
    tx = can_tx; st = is_stuff;
    force_en = fe; force_val = fv; sp = 1'b1;
    @(negedge clk);
    sp = 1'b0; force_en = 1'b0;
    dn = req.done; al = req.arb_lost; be = req.bit_error;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({can_tx, req.busy, is_stuff, req.done, req.arb_lost, req.bit_error} !== 6'b100000 || state !== IDLE) begin
      errors++;
      $display("FAIL reset: got tx/busy/stuff/done/arb/err=%b state=%0d want 100000 state=0",
               {can_tx, req.busy, is_stuff, req.done, req.arb_lost, req.bit_error}, state);
    end
  endtask

  task automatic test_basic;
    logic tx, st, dn, al, be;
    logic [3:0] exp_tx = 4'b1010;
    start_frame({4'b1010, 12'b0}, 8'd4, 8'd4, 8'd0);
    checks++;
    if (req.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", req.busy); end
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0, 1'b0, tx, st, dn, al, be);
      checks++;
      if ({tx, st, dn, al, be} !== {exp_tx[3-i], 1'b0, (i == 3), 2'b00}) begin
        errors++;
        $display("FAIL basic bit %0d: got tx/st/done/arb/err=%b want %b", i, {tx, st, dn, al, be},
                 {exp_tx[3-i], 1'b0, (i == 3), 2'b00});
      end
    end
    checks++;
    if ({req.busy, can_tx} !== 2'b01) begin
      errors++; $display("FAIL basic_end: got busy/tx=%b want 01", {req.busy, can_tx});
    end
    @(negedge clk);
    checks++;
    if (req.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", req.done); end
  endtask

  task automatic test_stuff_bit;
    logic tx, st, dn, al, be;
    logic [7:0] exp_tx = 8'b0000_0111;
    logic [7:0] exp_st = 8'b0000_0100;
    start_frame({7'b0000011, 9'b0}, 8'd7, 8'd7, 8'd0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 1'b0, tx, st, dn, al, be);
      checks++;
      if ({tx, st, dn, al, be} !== {exp_tx[7-i], exp_st[7-i], (i == 7), 2'b00}) begin
        errors++;
        $display("FAIL stuff_bit %0d: got tx/st/done/arb/err=%b want %b", i, {tx, st, dn, al, be},
                 {exp_tx[7-i], exp_st[7-i], (i == 7), 2'b00});
      end
    end
  endtask

  task automatic test_stuff_region;
    logic tx, st, dn, al, be;
    logic [6:0] exp_tx = 7'b1111100;
    logic [6:0] exp_st = 7'b0000010;
    start_frame({6'b111110, 10'b0}, 8'd6, 8'd5, 8'd0);
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b0, 1'b0, tx, st, dn, al, be);
      checks++;
      if ({tx, st, dn, al, be} !== {exp_tx[6-i], exp_st[6-i], (i == 6), 2'b00}) begin
        errors++;
        $display("FAIL stuff_region %0d: got tx/st/done/arb/err=%b want %b", i, {tx, st, dn, al, be},
                 {exp_tx[6-i], exp_st[6-i], (i == 6), 2'b00});
      end
    end
    checks++;
    if (req.busy !== 1'b0) begin errors++; $display("FAIL stuff_region_busy: got %b want 0", req.busy); end
  endtask

  task automatic test_arb_lost;
    logic tx, st, dn, al, be;
    logic [3:0] exp_tx = 4'b0101;
    // Recessive bit 3 read back dominant: arbitration lost.
    start_frame({12'b0101_0101_0101, 4'b0}, 8'd12, 8'd12, 8'd11);
    for (int i = 0; i < 4; i++) begin
      send_bit(i == 3, 1'b0, tx, st, dn, al, be);
      checks++;
      if ({tx, dn, al, be} !== {exp_tx[3-i], 1'b0, (i == 3), 1'b0}) begin
        errors++;
        $display("FAIL arb_lost bit %0d: got tx/done/arb/err=%b want %b", i, {tx, dn, al, be},
                 {exp_tx[3-i], 1'b0, (i == 3), 1'b0});
      end
    end
    checks++;
    if ({can_tx, req.busy} !== 2'b10 || state !== IDLE) begin
      errors++; $display("FAIL arb_abort: got tx/busy=%b state=%0d want 10 state=0", {can_tx, req.busy}, state);
    end
    @(negedge clk);
    checks++;
    if (req.arb_lost !== 1'b0) begin errors++; $display("FAIL arb_pulse: got %b want 0", req.arb_lost); end
    // Dominant bit 2 read back recessive inside arbitration: bit error.
    start_frame({12'b0101_0101_0101, 4'b0}, 8'd12, 8'd12, 8'd11);
    for (int i = 0; i < 3; i++) begin
      send_bit(i == 2, 1'b1, tx, st, dn, al, be);
      checks++;
      if ({tx, dn, al, be} !== {exp_tx[3-i], 2'b00, (i == 2)}) begin
        errors++;
        $display("FAIL arb_dom_err bit %0d: got tx/done/arb/err=%b want %b", i, {tx, dn, al, be},
                 {exp_tx[3-i], 2'b00, (i == 2)});
      end
    end
  endtask

  task automatic test_stuff_error;
    logic tx, st, dn, al, be;
    logic [5:0] exp_tx = 6'b111110;
    start_frame({8'b1111_1000, 8'b0}, 8'd8, 8'd8, 8'd1);
    for (int i = 0; i < 6; i++) begin
      send_bit(i == 5, 1'b1, tx, st, dn, al, be);
      checks++;
      if ({tx, st, dn, al, be} !== {exp_tx[5-i], (i == 5), 2'b00, (i == 5)}) begin
        errors++;
        $display("FAIL stuff_error bit %0d: got tx/st/done/arb/err=%b want %b", i, {tx, st, dn, al, be},
                 {exp_tx[5-i], (i == 5), 2'b00, (i == 5)});
      end
    end
    checks++;
    if ({can_tx, req.busy, is_stuff} !== 3'b100) begin
      errors++; $display("FAIL stuff_error_abort: got tx/busy/st=%b want 100", {can_tx, req.busy, is_stuff});
    end
  endtask

  task automatic test_unchecked;
    logic tx, st, dn, al, be;
    logic [5:0] exp_tx = 6'b101010;
    start_frame({6'b101010, 10'b0}, 8'd6, 8'd4, 8'd0);
    for (int i = 0; i < 6; i++) begin
      send_bit(i >= 4, ~exp_tx[5-i], tx, st, dn, al, be);
      checks++;
      if ({tx, st, dn, al, be} !== {exp_tx[5-i], 1'b0, (i == 5), 2'b00}) begin
        errors++;
        $display("FAIL unchecked bit %0d: got tx/st/done/arb/err=%b want %b", i, {tx, st, dn, al, be},
                 {exp_tx[5-i], 1'b0, (i == 5), 2'b00});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic tx, st, dn, al, be;
    start_frame({4'b1010, 12'b0}, 8'd4, 8'd4, 8'd0);
    send_bit(1'b0, 1'b0, tx, st, dn, al, be);
    send_bit(1'b0, 1'b0, tx, st, dn, al, be);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({can_tx, req.busy, is_stuff, req.done, req.arb_lost, req.bit_error} !== 6'b100000 || state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: got tx/busy/stuff/done/arb/err=%b state=%0d want 100000 state=0",
               {can_tx, req.busy, is_stuff, req.done, req.arb_lost, req.bit_error}, state);
    end
  endtask

  task automatic test_start_busy;
    logic tx, st, dn, al, be;
    logic [3:0] exp_tx = 4'b1010;
    start_frame({4'b1010, 12'b0}, 8'd4, 8'd4, 8'd0);
    send_bit(1'b0, 1'b0, tx, st, dn, al, be);
    start_frame(16'h0000, 8'd2, 8'd2, 8'd0);
    for (int i = 1; i < 4; i++) begin
      send_bit(1'b0, 1'b0, tx, st, dn, al, be);
      checks++;
      if ({tx, dn} !== {exp_tx[3-i], (i == 3)}) begin
        errors++;
        $display("FAIL start_busy bit %0d: got tx/done=%b want %b", i, {tx, dn}, {exp_tx[3-i], (i == 3)});
      end
    end
  endtask

  task automatic test_zero_len;
    logic tx, st, dn, al, be;
    start_frame(16'h0000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (req.busy !== 1'b0 || state !== IDLE) begin
      errors++; $display("FAIL zero_len: got busy=%b state=%0d want busy=0 state=0", req.busy, state);
    end
    send_bit(1'b0, 1'b0, tx, st, dn, al, be);
    checks++;
    if ({tx, st, dn} !== 3'b100) begin
      errors++; $display("FAIL zero_len_idle: got tx/st/done=%b want 100", {tx, st, dn});
    end
  endtask

  initial begin
    reset = 1'b1; tx_pt = 1'b0; sp = 1'b0; force_en = 1'b0; force_val = 1'b0;
    req.start = 1'b0; req.frame = '0; req.frame_len = '0; req.stuff_len = '0; req.arb_len = '0;
    test_reset;
    test_basic;
    test_stuff_bit;
    test_stuff_region;
    test_arb_lost;
    test_stuff_error;
    test_unchecked;
    test_reset_mid;
    test_start_busy;
    test_zero_len;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
